// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: default geometry,
// derived field widths and the controller state encoding.
package dcache_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int LINES_DEF      = 4;
    localparam int LINE_BYTES_DEF = 16;

    localparam int OFFSET_W = $clog2(LINE_BYTES_DEF);
    localparam int INDEX_W  = $clog2(LINES_DEF);
    localparam int TAG_W    = ADDR_W_DEF - INDEX_W - OFFSET_W;
    localparam int LINE_W   = 8 * LINE_BYTES_DEF;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] REFILL    = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the cache: valid/dirty/tag/data per line, read
// combinationally by index, written by store hits (byte or word merge)
// and by refills (whole line).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES      = LINES_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int TAG_BITS   = TAG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(LINES)-1:0]  index,
    output logic                      valid,
    output logic                      dirty,
    output logic [TAG_BITS-1:0]       tag,
    output logic [8*LINE_BYTES-1:0]   line,
    input  logic                      st_we,
    input  logic                      st_byte,
    input  logic [$clog2(LINE_BYTES)-1:0] st_off,
    input  logic [31:0]               st_data,
    input  logic                      fill_we,
    input  logic [TAG_BITS-1:0]       fill_tag,
    input  logic [8*LINE_BYTES-1:0]   fill_line,
    input  logic                      clr_dirty
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int LN_W  = 8 * LINE_BYTES;

    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [LN_W-1:0]     lines [LINES];

    assign valid = valid_bits[index];
    assign dirty = dirty_bits[index];
    assign tag   = tags[index];
    assign line  = lines[index];

    // Line status bits: cleared by reset, set by refill and store hits,
    // dirty dropped once the victim has been written back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            if (fill_we) begin
                valid_bits[index] <= 1'b1;
                dirty_bits[index] <= 1'b0;
            end else if (st_we) begin
                dirty_bits[index] <= 1'b1;
            end else if (clr_dirty) begin
                dirty_bits[index] <= 1'b0;
            end
        end
    end

    // Tag and data contents: refill replaces the line, a store hit merges
    // one byte or one aligned word into it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tags[index]  <= fill_tag;
            lines[index] <= fill_line;
        end else if (st_we) begin
            if (st_byte) begin
                lines[index][{st_off, 3'b000} +: 8] <= st_data[7:0];
            end else begin
                lines[index][{st_off[OFF_W-1:2], 5'b00000} +: 32] <= st_data;
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete in
// the request cycle; misses optionally write back the dirty victim and
// then refill the line through a request/acknowledge handshake.
module dcache
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINES      = LINES_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    store,
    input  logic                    byte_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    dhit,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_wline,
    input  logic                    mem_ack,
    input  logic [8*LINE_BYTES-1:0] mem_rline
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LN_W  = 8 * LINE_BYTES;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TG_W-1:0]  tag;
    logic             line_valid;
    logic             line_dirty;
    logic [TG_W-1:0]  line_tag;
    logic [LN_W-1:0]  line_data;
    logic             access;
    logic             in_idle;
    logic             in_wb;
    logic             in_rf;
    logic             hit;

    // Byte lane or aligned word out of a cache line.
    function automatic logic [31:0] pick(input logic [LN_W-1:0] data,
                                         input logic [OFF_W-1:0] off,
                                         input logic byte_sel);
        logic [31:0] r;
        if (byte_sel) r = {24'h0, data[{off, 3'b000} +: 8]};
        else          r = data[{off[OFF_W-1:2], 5'b00000} +: 32];
        return r;
    endfunction

    assign offset  = addr[OFF_W-1:0];
    assign index   = addr[OFF_W +: IDX_W];
    assign tag     = addr[ADDR_W-1 -: TG_W];
    assign access  = load | store;
    assign in_idle = (state == IDLE);
    assign in_wb   = (state == WRITEBACK);
    assign in_rf   = (state == REFILL);
    assign hit     = in_idle & access & line_valid & (line_tag == tag);

    dcache_array #(
        .LINES      (LINES),
        .LINE_BYTES (LINE_BYTES),
        .TAG_BITS   (TG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (index),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .line      (line_data),
        .st_we     (hit & store),
        .st_byte   (byte_en),
        .st_off    (offset),
        .st_data   (wdata),
        .fill_we   (in_rf & mem_ack),
        .fill_tag  (tag),
        .fill_line (mem_rline),
        .clr_dirty (in_wb & mem_ack)
    );

    // Next-state: a miss picks write-back or refill from the victim's
    // dirty bit; each memory phase ends on its acknowledge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (access && !hit)
                           state_nx = (line_valid && line_dirty) ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ack) state_nx = REFILL;
            REFILL:    if (mem_ack) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Controller state; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Memory-side request: victim line during write-back, requested line
    // address during refill, all zero otherwise and while in reset.
    always_comb begin
        mem_addr  = '0;
        mem_wline = '0;
        if (!reset) begin
            if (in_wb) begin
                mem_addr  = {line_tag, index, {OFF_W{1'b0}}};
                mem_wline = line_data;
            end else if (in_rf) begin
                mem_addr = {tag, index, {OFF_W{1'b0}}};
            end
        end
    end

    assign mem_req = ~reset & (in_wb | in_rf);
    assign mem_we  = ~reset & in_wb;
    assign dhit    = ~reset & in_idle & (~access | hit);
    assign rdata   = (~reset & hit & load & ~store) ? pick(line_data, offset, byte_en) : 32'h0;

endmodule
